// File: rtl/exp_pkg.sv
// Shared definitions for the exp pipe and its result FIFO.
//   EXP_DATA_W     result width (x^8 of a 7-bit input)
//   EXP_IN_W       exp pipe input width
//   EXP_TEST_TIMES results expected per run
//   exp_state_e    run-tracking FSM states
//   clog2()        ceiling log2, usable in constant expressions
package exp_pkg;

    localparam int unsigned EXP_DATA_W     = 64;
    localparam int unsigned EXP_IN_W       = 7;
    localparam int unsigned EXP_TEST_TIMES = 100;

    typedef enum logic [1:0] {
        StIdle,
        StCollect,
        StDrain,
        StDone
    } exp_state_e;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        while ((64'd1 << res) < 64'(value)) begin
            res = res + 1;
        end
        return res;
    endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO: storage, pointers, count and flags.
//   clk, rst   clock and synchronous active-high reset
//   push       write wdata this cycle (caller guarantees !full or simultaneous pop)
//   pop        drop the head entry this cycle (caller guarantees !empty)
//   wdata      write data
//   rdata      head entry, read combinationally from storage
//   count      entries stored
//   full       count == DEPTH
//   empty      count == 0
module sync_fifo_fwft
    import exp_pkg::*;
#(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DATA_W-1:0]            wdata,
    output logic [DATA_W-1:0]            rdata,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned AddrW = clog2(DEPTH);
    localparam int unsigned PtrW  = AddrW + 1;
    localparam int unsigned CntW  = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]   count_q, count_d;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
            count_q <= count_d;
        end
    end

    // Storage is deliberately not reset; the pointers alone define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[AddrW-1:0]] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q[AddrW-1:0]];
    assign count = count_q;
    // Extra pointer MSB distinguishes full from empty when the address bits match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                   (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);

endmodule

// File: rtl/exp_result_fifo.sv
// Result buffer behind param_exp_pipe. Captures each result into a FWFT FIFO, presents it on
// a ready/valid output, flags dropped results and reports when a full run has been drained.
//   clk, rst     clock and synchronous active-high reset
//   i_valid      result strobe from the exp pipe
//   i_data       result value
//   o_valid      head entry available
//   o_data       head entry (valid only while o_valid)
//   i_ready      consumer takes the head this cycle
//   o_count      entries stored
//   o_full       FIFO full
//   o_empty      FIFO empty
//   o_overflow   sticky: at least one result was dropped
//   o_rcv_cnt    results accepted this run, saturating at TEST_TIMES
//   o_done       every result of the run accepted and drained
module exp_result_fifo
    import exp_pkg::*;
#(
    parameter int unsigned DATA_W     = EXP_DATA_W,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned TEST_TIMES = EXP_TEST_TIMES
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              i_valid,
    input  logic [DATA_W-1:0]                 i_data,
    output logic                              o_valid,
    output logic [DATA_W-1:0]                 o_data,
    input  logic                              i_ready,
    output logic [$clog2(DEPTH+1)-1:0]        o_count,
    output logic                              o_full,
    output logic                              o_empty,
    output logic                              o_overflow,
    output logic [$clog2(TEST_TIMES+1)-1:0]   o_rcv_cnt,
    output logic                              o_done
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned RcvW = $clog2(TEST_TIMES + 1);

    logic            fifo_full, fifo_empty;
    logic [CntW-1:0] fifo_count;
    logic            push, pop, drop, rcv_open, last_push;

    logic [RcvW-1:0] rcv_cnt_q, rcv_cnt_d;
    logic            overflow_q, overflow_d;
    exp_state_e      state_q, state_d;

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign pop       = !fifo_empty && i_ready;
    assign rcv_open  = (rcv_cnt_q < RcvW'(TEST_TIMES));
    assign push      = i_valid && (!fifo_full || pop) && rcv_open;
    assign drop      = i_valid && !push;
    assign last_push = push && (rcv_cnt_q == RcvW'(TEST_TIMES - 1));

    sync_fifo_fwft #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (i_data),
        .rdata (o_data),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        rcv_cnt_d  = rcv_cnt_q;
        overflow_d = overflow_q | drop;
        state_d    = state_q;
        if (push) rcv_cnt_d = rcv_cnt_q + RcvW'(1);
        case (state_q)
            StIdle: begin
                // A one-result run goes straight to draining.
                if (push) state_d = last_push ? StDrain : StCollect;
            end
            StCollect: begin
                if (last_push) state_d = StDrain;
            end
            StDrain: begin
                if (fifo_count == '0 || (fifo_count == CntW'(1) && pop)) state_d = StDone;
            end
            StDone: begin
                state_d = StDone;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rcv_cnt_q  <= '0;
            overflow_q <= 1'b0;
            state_q    <= StIdle;
        end else begin
            rcv_cnt_q  <= rcv_cnt_d;
            overflow_q <= overflow_d;
            state_q    <= state_d;
        end
    end

    assign o_valid    = !fifo_empty;
    assign o_empty    = fifo_empty;
    assign o_full     = fifo_full;
    assign o_count    = fifo_count;
    assign o_overflow = overflow_q;
    assign o_rcv_cnt  = rcv_cnt_q;
    assign o_done     = (state_q == StDone);

endmodule

// File: tb/tb_exp_result_fifo.sv
// Scoreboard bench for exp_result_fifo. A default build (TEST_TIMES=100) and a TEST_TIMES=4
// build share clk/rst/inputs; sel picks which one the model tracks and checks.
module tb_exp_result_fifo;

    localparam int unsigned DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_ready = 1'b0;
    logic [63:0] i_data = '0;
    logic        sel = 1'b0;

    always #5 clk = ~clk;

    logic        a_valid, a_full, a_empty, a_ovf, a_done;
    logic [63:0] a_data;
    logic [3:0]  a_count;
    logic [6:0]  a_rcv;
    logic        b_valid, b_full, b_empty, b_ovf, b_done;
    logic [63:0] b_data;
    logic [3:0]  b_count;
    logic [2:0]  b_rcv;

    exp_result_fifo u_dut (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_valid    (a_valid),
        .o_data     (a_data),
        .i_ready    (i_ready),
        .o_count    (a_count),
        .o_full     (a_full),
        .o_empty    (a_empty),
        .o_overflow (a_ovf),
        .o_rcv_cnt  (a_rcv),
        .o_done     (a_done)
    );

    exp_result_fifo #(
        .TEST_TIMES (4)
    ) u_dut4 (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (i_valid),
        .i_data     (i_data),
        .o_valid    (b_valid),
        .o_data     (b_data),
        .i_ready    (i_ready),
        .o_count    (b_count),
        .o_full     (b_full),
        .o_empty    (b_empty),
        .o_overflow (b_ovf),
        .o_rcv_cnt  (b_rcv),
        .o_done     (b_done)
    );

    // Model state
    int          m_count, m_rcv, tt;
    bit          m_ovf, m_done;
    logic [63:0] exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic [63:0] pow8(input int x);
        logic [63:0] p;
        p = 64'(x);
        p = p * p;
        p = p * p;
        p = p * p;
        return p;
    endfunction

    task automatic check_outputs();
        logic        vl, fl, em, ov, dn;
        logic [63:0] dt;
        logic [3:0]  ct;
        logic [6:0]  rc;
        vl = sel ? b_valid : a_valid;
        fl = sel ? b_full  : a_full;
        em = sel ? b_empty : a_empty;
        ov = sel ? b_ovf   : a_ovf;
        dn = sel ? b_done  : a_done;
        dt = sel ? b_data  : a_data;
        ct = sel ? b_count : a_count;
        rc = sel ? {4'b0, b_rcv} : a_rcv;
        check("o_valid",    64'(vl), 64'(m_count != 0));
        check("o_count",    64'(ct), 64'(m_count));
        check("o_full",     64'(fl), 64'(m_count == int'(DEPTH)));
        check("o_empty",    64'(em), 64'(m_count == 0));
        check("o_overflow", 64'(ov), 64'(m_ovf));
        check("o_rcv_cnt",  64'(rc), 64'(m_rcv));
        check("o_done",     64'(dn), 64'(m_done));
        if (m_count != 0 && exp_q.size() != 0) check("o_data", dt, exp_q[0]);
    endtask

    // One clock cycle with the given inputs; inputs change and outputs are sampled at negedge.
    task automatic step(input bit v, input logic [63:0] d, input bit r);
        bit          pop_m, push_m;
        logic [63:0] junk;
        i_valid = v;
        i_data  = d;
        i_ready = r;
        check_outputs();
        pop_m  = (m_count != 0) && r;
        push_m = v && (m_count < int'(DEPTH) || pop_m) && (m_rcv < tt);
        if (pop_m) junk = exp_q.pop_front();
        if (v && !push_m) m_ovf = 1'b1;
        if (push_m) begin
            exp_q.push_back(d);
            m_rcv++;
            m_count++;
        end
        if (pop_m) m_count--;
        if (m_rcv == tt && m_count == 0) m_done = 1'b1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst     = 1'b0;
        m_count = 0;
        m_rcv   = 0;
        m_ovf   = 1'b0;
        m_done  = 1'b0;
        tt      = sel ? 4 : 100;
        exp_q.delete();
        check_outputs();
    endtask

    initial begin
        // 1: full run of 0..99 with the consumer always ready
        sel = 1'b0;
        do_reset();
        for (int x = 0; x < 100; x++) step(1'b1, pow8(x), 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1);
        check_outputs();

        // 2: stalled consumer, 10 results, last two dropped, then drain
        do_reset();
        for (int x = 0; x < 10; x++) step(1'b1, pow8(x + 1), 1'b0);
        for (int k = 0; k < 10; k++) step(1'b0, '0, 1'b1);
        check_outputs();

        // 3: fill, then simultaneous push and pop while full
        do_reset();
        for (int x = 0; x < 8; x++) step(1'b1, pow8(x), 1'b0);
        for (int x = 8; x < 13; x++) step(1'b1, pow8(x), 1'b1);
        for (int k = 0; k < 10; k++) step(1'b0, '0, 1'b1);
        check_outputs();

        // 4: 20 results with ready toggling each cycle; pointers wrap
        do_reset();
        begin
            int x;
            x = 20;
            for (int c = 0; c < 30; c++) begin
                if (c % 3 != 2) begin
                    step(1'b1, pow8(x), (c % 2) == 1);
                    x++;
                end else begin
                    step(1'b0, '0, (c % 2) == 1);
                end
            end
        end
        for (int k = 0; k < 12; k++) step(1'b0, '0, 1'b1);
        check_outputs();

        // 5: TEST_TIMES=4 build, 5 results, 5th dropped, done after drain
        sel = 1'b1;
        do_reset();
        for (int x = 0; x < 5; x++) step(1'b1, pow8(x + 3), 1'b0);
        for (int k = 0; k < 6; k++) step(1'b0, '0, 1'b1);
        check_outputs();

        // 6: reset mid-run with 5 entries stored, then a fresh 0..3 run
        sel = 1'b0;
        do_reset();
        for (int x = 0; x < 5; x++) step(1'b1, pow8(x + 40), 1'b0);
        do_reset();
        for (int x = 0; x < 4; x++) step(1'b1, pow8(x), 1'b1);
        for (int k = 0; k < 3; k++) step(1'b0, '0, 1'b1);
        check_outputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
